// File: rtl/round_sequencer.sv
// Round sequencer: arms a timed round on a Start edge, counts elapsed seconds,
// and ends the round on Correct (a win) or when the round length runs out.
module round_sequencer #(
    parameter int unsigned CLKS_PER_SEC = 50000000,
    parameter int unsigned ROUND_LEN    = 99
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Start,
    input  logic       Pause,
    input  logic       Correct,
    output logic [6:0] OngoingTimer,
    output logic       startEq2,
    output logic       Running,
    output logic       RoundDone,
    output logic       Timeout,
    output logic [3:0] Wins
);

    localparam int unsigned PrescW = (CLKS_PER_SEC > 2) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [PrescW-1:0] PrescMax = PrescW'(CLKS_PER_SEC - 1);
    localparam logic [6:0] RoundLenV = 7'(ROUND_LEN);

    typedef enum logic [1:0] {StIdle, StArm, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [PrescW-1:0] presc_q, presc_d;
    logic [6:0]        timer_q, timer_d;
    logic              timeout_q, timeout_d;
    logic [3:0]        wins_q, wins_d;
    logic              start_q;
    // Set by reset; blocks edge detection until Start has been seen low, so a
    // button held through reset cannot launch a round.
    logic              start_block_q;
    logic              rise;

    assign rise = Start & ~start_q & ~start_block_q;

    // Start history and reset-time edge blocker.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            start_q       <= 1'b0;
            start_block_q <= 1'b1;
        end else begin
            start_q <= Start;
            if (!Start) begin
                start_block_q <= 1'b0;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
            wins_q    <= '0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
            wins_q    <= wins_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        wins_d    = wins_q;
        unique case (state_q)
            StIdle, StDone: begin
                // Clearing on entry to ARM keeps stale round data off the outputs.
                if (rise) begin
                    state_d   = StArm;
                    presc_d   = '0;
                    timer_d   = '0;
                    timeout_d = 1'b0;
                end
            end
            StArm: begin
                state_d   = StRun;
                presc_d   = '0;
                timer_d   = '0;
                timeout_d = 1'b0;
            end
            StRun: begin
                if (Correct) begin
                    // A correct answer beats a simultaneous time-out.
                    state_d = StDone;
                    if (wins_q != 4'hF) begin
                        wins_d = wins_q + 4'd1;
                    end
                end else if (timer_q == RoundLenV) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end else if (!Pause) begin
                    if (presc_q == PrescMax) begin
                        presc_d = '0;
                        timer_d = timer_q + 7'd1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state only.
    assign startEq2     = (state_q == StArm);
    assign Running      = (state_q == StRun);
    assign RoundDone    = (state_q == StDone);
    assign OngoingTimer = timer_q;
    assign Timeout      = timeout_q;
    assign Wins         = wins_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer with CLKS_PER_SEC = 4, ROUND_LEN = 5.
module tb_round_sequencer;

    localparam int KReset = 0;
    localparam int KStart = 1;
    localparam int KRun   = 2;
    localparam int KTick  = 3;
    localparam int KDone  = 4;

    typedef struct {
        int          kind;
        int          delta;  // cycles since previous event, 0 = don't care
        logic [14:0] vec;    // {startEq2, Running, RoundDone, Timeout, Wins, OngoingTimer}
    } exp_t;

    logic       Clock = 1'b0;
    logic       Resetn, Start, Pause, Correct;
    logic [6:0] OngoingTimer;
    logic       startEq2, Running, RoundDone, Timeout;
    logic [3:0] Wins;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic rst_seen = 1'b0;

    round_sequencer #(
        .CLKS_PER_SEC(4),
        .ROUND_LEN   (5)
    ) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .Start       (Start),
        .Pause       (Pause),
        .Correct     (Correct),
        .OngoingTimer(OngoingTimer),
        .startEq2    (startEq2),
        .Running     (Running),
        .RoundDone   (RoundDone),
        .Timeout     (Timeout),
        .Wins        (Wins)
    );

    always #5 Clock = ~Clock;

    // Remember whether the DUT saw reset at the last edge.
    always @(posedge Clock) rst_seen <= !Resetn;

    task automatic push(input int kind, input int delta, input logic st, input logic run,
                        input logic dn, input logic to, input logic [3:0] w,
                        input logic [6:0] t);
        exp_t e;
        e.kind  = kind;
        e.delta = delta;
        e.vec   = {st, run, dn, to, w, t};
        sb_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic wait_timer(input logic [6:0] v);
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1);
            if (OngoingTimer == v) found = 1'b1;
        end
        if (!found) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_timer: OngoingTimer=%0d, required %0d within 200 cycles",
                     OngoingTimer, v);
        end
    endtask

    // Monitor: classify each cycle's observable event and check it against the queue.
    initial begin
        int          cyc = 0;
        int          last_cyc = 0;
        int          kind;
        int          delta;
        logic        prev_running = 1'b0;
        logic        prev_done = 1'b0;
        logic [6:0]  prev_timer = '0;
        logic [14:0] act;
        exp_t        e;
        forever begin
            @(negedge Clock);
            cyc++;
            kind = -1;
            if (rst_seen) kind = KReset;
            else if (startEq2) kind = KStart;
            else if (Running && !prev_running) kind = KRun;
            else if (Running && prev_running && OngoingTimer != prev_timer) kind = KTick;
            else if (RoundDone && !prev_done) kind = KDone;
            if (kind >= 0) begin
                act = {startEq2, Running, RoundDone, Timeout, Wins, OngoingTimer};
                delta = cyc - last_cyc;
                last_cyc = cyc;
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: kind=%0d outputs=%h, none required",
                             kind, act);
                end else begin
                    e = sb_q.pop_front();
                    if (e.kind != kind || (e.delta != 0 && e.delta != delta) || act !== e.vec)
                    begin
                        n_fail++;
                        $display("FAIL event: got kind=%0d delta=%0d outputs=%h, required kind=%0d delta=%0d outputs=%h",
                                 kind, delta, act, e.kind, e.delta, e.vec);
                    end
                end
            end
            prev_running = Running;
            prev_done    = RoundDone;
            prev_timer   = OngoingTimer;
        end
    end

    // Stimulus.
    initial begin
        int unsigned w;
        Resetn  = 1'b0;
        Start   = 1'b0;
        Pause   = 1'b0;
        Correct = 1'b0;
        push(KReset, 0, 0, 0, 0, 0, 4'd0, 7'd0);
        step(1);
        Resetn = 1'b1;
        step(2);

        // Round 1: runs out of time; Start stays high and Correct in DONE is ignored.
        push(KStart, 0, 1, 0, 0, 0, 4'd0, 7'd0);
        push(KRun, 1, 0, 1, 0, 0, 4'd0, 7'd0);
        for (int t = 1; t <= 5; t++) push(KTick, 4, 0, 1, 0, 0, 4'd0, 7'(t));
        push(KDone, 1, 0, 0, 1, 1, 4'd0, 7'd5);
        Start = 1'b1;
        step(30);
        Correct = 1'b1;
        step(2);
        Correct = 1'b0;
        step(2);

        // Round 2: win at second 2.
        push(KStart, 0, 1, 0, 0, 0, 4'd0, 7'd0);
        push(KRun, 1, 0, 1, 0, 0, 4'd0, 7'd0);
        push(KTick, 4, 0, 1, 0, 0, 4'd0, 7'd1);
        push(KTick, 4, 0, 1, 0, 0, 4'd0, 7'd2);
        push(KDone, 1, 0, 0, 1, 0, 4'd1, 7'd2);
        Start = 1'b0;
        step(1);
        Start = 1'b1;
        wait_timer(7'd2);
        Correct = 1'b1;
        step(1);
        Correct = 1'b0;
        step(3);

        // Round 3: pause 10 cycles at second 3, then win exactly at the limit.
        push(KStart, 0, 1, 0, 0, 0, 4'd1, 7'd0);
        push(KRun, 1, 0, 1, 0, 0, 4'd1, 7'd0);
        for (int t = 1; t <= 3; t++) push(KTick, 4, 0, 1, 0, 0, 4'd1, 7'(t));
        push(KTick, 14, 0, 1, 0, 0, 4'd1, 7'd4);
        push(KTick, 4, 0, 1, 0, 0, 4'd1, 7'd5);
        push(KDone, 1, 0, 0, 1, 0, 4'd2, 7'd5);
        Start = 1'b0;
        step(1);
        Start = 1'b1;
        wait_timer(7'd3);
        step(1);
        Pause = 1'b1;
        step(10);
        Pause = 1'b0;
        wait_timer(7'd5);
        Correct = 1'b1;
        step(1);
        Correct = 1'b0;
        step(2);

        // Quick wins until Wins saturates.
        for (int k = 3; k <= 16; k++) begin
            w = (k > 15) ? 15 : k;
            push(KStart, 0, 1, 0, 0, 0, 4'(k - 1), 7'd0);
            push(KRun, 1, 0, 1, 0, 0, 4'(k - 1), 7'd0);
            push(KDone, 1, 0, 0, 1, 0, 4'(w), 7'd0);
            Start = 1'b0;
            step(1);
            Start = 1'b1;
            step(2);
            Correct = 1'b1;
            Start   = 1'b0;
            step(1);
            Correct = 1'b0;
        end
        step(2);

        // Mid-round Start edge ignored, then reset at second 4 with Start held high.
        push(KStart, 0, 1, 0, 0, 0, 4'd15, 7'd0);
        push(KRun, 1, 0, 1, 0, 0, 4'd15, 7'd0);
        for (int t = 1; t <= 4; t++) push(KTick, 4, 0, 1, 0, 0, 4'd15, 7'(t));
        push(KReset, 0, 0, 0, 0, 0, 4'd0, 7'd0);
        Start = 1'b0;
        step(1);
        Start = 1'b1;
        wait_timer(7'd1);
        Start = 1'b0;
        step(1);
        Start = 1'b1;
        step(1);
        wait_timer(7'd4);
        Resetn = 1'b0;
        step(1);
        Resetn = 1'b1;
        step(6);

        // A fresh press after reset starts a round with Wins counting from zero.
        push(KStart, 0, 1, 0, 0, 0, 4'd0, 7'd0);
        push(KRun, 1, 0, 1, 0, 0, 4'd0, 7'd0);
        push(KDone, 1, 0, 0, 1, 0, 4'd1, 7'd0);
        Start = 1'b0;
        step(1);
        Start = 1'b1;
        step(2);
        Correct = 1'b1;
        step(1);
        Correct = 1'b0;
        step(5);

        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL missing_event: never observed, required kind=%0d outputs=%h",
                     e.kind, e.vec);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 SHALL have parameter CLKS_PER_SEC, default 50000000, Clock cycles per one-second tick (legal range 2 and up).
REQ-002 SHALL have parameter ROUND_LEN, default 99, round length in seconds (legal range 1..127).
REQ-003 SHALL have port Clock, input, 1, system clock; all state changes on posedge.
REQ-004 SHALL have port Resetn, input, 1; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port Start, input, 1, level from pushbutton; only its rising edge is acted on.
REQ-006 SHALL have port Pause, input, 1, level; high freezes timing.
REQ-007 SHALL have port Correct, input, 1, level from the downstream equation stage.
REQ-008 SHALL have port OngoingTimer, output, 7, elapsed whole seconds in the current round; feeds the equation stage.
REQ-009 SHALL have port startEq2, output, 1, one-cycle round-start pulse to the equation stage.
REQ-010 SHALL have port Running, output, 1, high in state RUN.
REQ-011 SHALL have port RoundDone, output, 1, high in state DONE.
REQ-012 SHALL have port Timeout, output, 1, high in DONE when the round ended by time limit.
REQ-013 SHALL have port Wins, output, 4, count of rounds ended by Correct.

Function
REQ-014 SHALL register Start each cycle; rise = Start high and previous sample low.
REQ-015 SHALL implement states IDLE, ARM, RUN, DONE; every output is registered or decoded from registered state only.
REQ-016 IDLE: rise -> ARM; otherwise stay.
REQ-017 ARM: lasts exactly one cycle; startEq2 = 1 in this cycle only; OngoingTimer and prescaler are 0 on the next cycle; Timeout clears; -> RUN.
REQ-018 RUN: prescaler counts 0..CLKS_PER_SEC-1 when Pause = 0; on wrap from CLKS_PER_SEC-1 to 0, OngoingTimer increments by 1.
REQ-019 RUN with Pause = 1: prescaler and OngoingTimer hold; Correct and the timeout check remain active.
REQ-020 RUN: Correct = 1 -> DONE next cycle; Wins increments by 1, saturating at 15.
REQ-021 RUN: OngoingTimer == ROUND_LEN and Correct = 0 -> DONE with Timeout = 1; OngoingTimer never exceeds ROUND_LEN.
REQ-022 Same-cycle Correct = 1 and OngoingTimer == ROUND_LEN: Correct takes precedence; Wins increments and Timeout stays 0.
REQ-023 DONE: OngoingTimer, Timeout and Wins hold; rise -> ARM (new round; Wins kept); Correct is ignored.
REQ-024 A rise in ARM or RUN SHALL be ignored (no restart mid-round).
REQ-025 A Start held high across a DONE->ARM transition SHALL NOT generate a second round; a new low-to-high edge is required.
REQ-026 startEq2 SHALL never be high for two consecutive cycles.

Reset
REQ-027 Resetn = 0 at a posedge SHALL force state IDLE, prescaler 0, Start history 0, OngoingTimer 0, startEq2 0, Running 0, RoundDone 0, Timeout 0, Wins 0, from any state including mid-round.
REQ-028 Resetn takes priority over all other inputs in the same cycle.

Verification (CLKS_PER_SEC = 4, ROUND_LEN = 5)
REQ-029 Reset, then Start 0->1 -> startEq2 high exactly 1 cycle, then Running = 1, OngoingTimer = 0, incrementing every 4 cycles: 1, 2, 3.
REQ-030 Run with Correct = 0 -> OngoingTimer reaches 5, next cycle RoundDone = 1, Timeout = 1, Wins = 0, OngoingTimer holds at 5.
REQ-031 Correct pulsed when OngoingTimer = 2 -> RoundDone = 1, Timeout = 0, Wins = 1; second round started by a new Start edge clears OngoingTimer and keeps Wins = 1.
REQ-032 Pause high 10 cycles at OngoingTimer = 3 -> value stays 3; after release it advances to 4 after the remaining prescaler count.
REQ-033 Correct and OngoingTimer == 5 in the same cycle -> Wins increments, Timeout = 0; 16 winning rounds -> Wins = 15.
REQ-034 Resetn low for 1 cycle mid-RUN at OngoingTimer = 4 -> all outputs 0 and state IDLE next cycle; Start held high through reset gives no round until it is released and pressed again.
